note_sequencer: RTL and testbench

Controller that sits between the PS/2 scan-code receiver and `Speaker`: parses make/break scan-code sequences, keeps a last-pressed-wins stack of held piano keys and drives the registered `note` code that `Speaker` turns into a tone. It decides which single note owns the speaker at any time and inserts silence when no key is held.

---
 rtl/note_sequencer.sv | 163 ++++++++++++++++
 tb/tb_note_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// PS/2 scan-code note sequencer: parses make/break codes, keeps a last-pressed-wins stack of held keys, drives Speaker's note.
// Optional NOTE_GAP_EN inserts GAP_CYCLES of silence between two different sounding notes.
module note_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  input  logic       panic,
  output logic [7:0] note,
  output logic       active,
  output logic [3:0] held_count
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parse_t;

  parse_t     state, state_next;
  logic       press_ev, release_ev;
  logic [3:0] ev_note;
  logic [3:0] stack      [DEPTH];
  logic [3:0] stack_next [DEPTH];
  logic [3:0] count, count_next;
  logic [3:0] target;
  logic [3:0] note_q;
  logic       found;
  int         found_idx;

  function automatic logic [3:0] key_of(input logic [7:0] code);
    case (code)
      8'h1C:   return 4'd1;
      8'h1D:   return 4'd2;
      8'h1B:   return 4'd3;
      8'h24:   return 4'd4;
      8'h23:   return 4'd5;
      8'h2B:   return 4'd6;
      8'h2C:   return 4'd7;
      8'h34:   return 4'd8;
      8'h35:   return 4'd9;
      8'h33:   return 4'd10;
      8'h3C:   return 4'd11;
      8'h3B:   return 4'd12;
      8'h42:   return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  assign ev_note = key_of(scan_data);

  always_ff @(posedge clk) begin
    if (rst || panic) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    press_ev   = 1'b0;
    release_ev = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_data == 8'hF0)      state_next = BRK;
          else if (scan_data == 8'hE0) state_next = EXT;
          else                         press_ev   = (ev_note != 4'd0);
        end
        BRK: begin
          release_ev = (ev_note != 4'd0);
          state_next = IDLE;
        end
        EXT:     state_next = (scan_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Entry 0 is the oldest key; releases close the hole so the newest stays on top.
  always_comb begin
    stack_next = stack;
    count_next = count;
    found      = 1'b0;
    found_idx  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count) && stack[i] == ev_note) begin
        found     = 1'b1;
        found_idx = i;
      end
    end
    if (press_ev && !found) begin
      if (int'(count) < DEPTH) begin
        for (int i = 0; i < DEPTH; i++)
          if (i == int'(count)) stack_next[i] = ev_note;
        count_next = count + 4'd1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) stack_next[i] = stack[i+1];
        stack_next[DEPTH-1] = ev_note;
      end
    end else if (release_ev && found) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= found_idx) stack_next[i] = stack[i+1];
      stack_next[DEPTH-1] = 4'd0;
      count_next = count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || panic) begin
      stack <= '{default: '0};
      count <= 4'd0;
    end else begin
      stack <= stack_next;
      count <= count_next;
    end
  end

  always_comb begin
    target = 4'd0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(count) == i + 1) target = stack[i];
  end

`ifdef NOTE_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [GW-1:0] gap_cnt;
  logic [3:0]    last_target;

  // gap_cnt holds the silent cycles still owed after the current one; a nonzero-to-nonzero change restarts it.
  always_ff @(posedge clk) begin
    if (rst || panic) begin
      note_q      <= 4'd0;
      gap_cnt     <= '0;
      last_target <= 4'd0;
    end else begin
      last_target <= target;
      if (target == 4'd0) begin
        note_q  <= 4'd0;
        gap_cnt <= '0;
      end else if (last_target != 4'd0 && target != last_target) begin
        note_q  <= 4'd0;
        gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (gap_cnt != '0) begin
        note_q  <= 4'd0;
        gap_cnt <= gap_cnt - 1'b1;
      end else begin
        note_q  <= target;
      end
    end
  end
`else
  // Panic silences the speaker at once rather than waiting for the empty stack to propagate.
  always_ff @(posedge clk) begin
    if (rst || panic) note_q <= 4'd0;
    else              note_q <= target;
  end
`endif

  assign note       = {4'd0, note_q};
  assign active     = (note_q != 4'd0);
  assign held_count = count;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized traffic against a queue-based key model.
// Define NOTE_GAP_EN on both RTL and bench to exercise the silence-gap build.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_data = 8'h00;
  logic       scan_valid = 1'b0;
  logic       panic = 1'b0;
  logic [7:0] note;
  logic       active;
  logic [3:0] held_count;

  int checks = 0;
  int failures = 0;

  int mstack[$];
  int mode = 0;
  int exp_note = 0;
  logic [7:0] codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                             8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

  note_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .scan_data(scan_data), .scan_valid(scan_valid),
    .panic(panic), .note(note), .active(active), .held_count(held_count)
  );

  always #5 clk = ~clk;

  function automatic int key_of(input logic [7:0] d);
    for (int i = 0; i < 13; i++) if (codes[i] == d) return i + 1;
    return 0;
  endfunction

  task automatic model_press(input int k);
    foreach (mstack[i]) if (mstack[i] == k) return;
    if (mstack.size() == DEPTH) void'(mstack.pop_front());
    mstack.push_back(k);
  endtask

  task automatic model_release(input int k);
    foreach (mstack[i]) if (mstack[i] == k) begin mstack.delete(i); return; end
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p, input logic r);
    int target;
    scan_valid = v; scan_data = d; panic = p; rst = r;
    target = (mstack.size() > 0) ? mstack[$] : 0;
    @(posedge clk);
    #1;
    if (r || p) begin
      mstack.delete(); mode = 0; exp_note = 0;
    end else begin
      exp_note = target;
      if (v) begin
        case (mode)
          0: if (d == 8'hF0) mode = 1;
             else if (d == 8'hE0) mode = 2;
             else if (key_of(d) != 0) model_press(key_of(d));
          1: begin if (key_of(d) != 0) model_release(key_of(d)); mode = 0; end
          2: mode = (d == 8'hF0) ? 3 : 0;
          default: mode = 0;
        endcase
      end
    end
    scan_valid = 1'b0; panic = 1'b0; rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d); applyStimulus(1'b1, d, 1'b0, 1'b0); endtask
  task automatic idle();                         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic do_panic();                     applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); endtask

  task automatic test_reset();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++; if (note !== 8'd0)       begin failures++; $display("[TB] FAIL reset_note got=%0d want=0", note); end
    checks++; if (active !== 1'b0)     begin failures++; $display("[TB] FAIL reset_active got=%0d want=0", active); end
    checks++; if (held_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_held got=%0d want=0", held_count); end
  endtask

  task automatic test_basic();
    send_byte(8'h1C);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL basic_held1 got=%0d want=1", held_count); end
    idle();
    checks++; if (note !== 8'd1)   begin failures++; $display("[TB] FAIL basic_note1 got=%0d want=1", note); end
    checks++; if (active !== 1'b1) begin failures++; $display("[TB] FAIL basic_active got=%0d want=1", active); end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (held_count !== 4'd0) begin failures++; $display("[TB] FAIL basic_held0 got=%0d want=0", held_count); end
    idle();
    checks++; if (note !== 8'd0)   begin failures++; $display("[TB] FAIL basic_note0 got=%0d want=0", note); end
    checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL basic_inactive got=%0d want=0", active); end
  endtask

  task automatic test_overlay();
    send_byte(8'h1C); idle();
    send_byte(8'h23);
    checks++; if (held_count !== 4'd2) begin failures++; $display("[TB] FAIL overlay_held2 got=%0d want=2", held_count); end
    idle();
    checks++; if (note !== 8'd5) begin failures++; $display("[TB] FAIL overlay_note5 got=%0d want=5", note); end
    send_byte(8'hF0); send_byte(8'h23);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL overlay_held1 got=%0d want=1", held_count); end
    idle();
    checks++; if (note !== 8'd1) begin failures++; $display("[TB] FAIL overlay_note1 got=%0d want=1", note); end
    send_byte(8'hF0); send_byte(8'h1C); idle();
    checks++; if (held_count !== 4'd0) begin failures++; $display("[TB] FAIL overlay_empty got=%0d want=0", held_count); end
  endtask

  task automatic test_depth();
    send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23); send_byte(8'h2B); send_byte(8'h34);
    checks++; if (held_count !== 4'd4) begin failures++; $display("[TB] FAIL depth_full got=%0d want=4", held_count); end
    idle();
    checks++; if (note !== 8'd8) begin failures++; $display("[TB] FAIL depth_note8 got=%0d want=8", note); end
    send_byte(8'hF0); send_byte(8'h34);
    checks++; if (held_count !== 4'd3) begin failures++; $display("[TB] FAIL depth_held3 got=%0d want=3", held_count); end
    idle();
    checks++; if (note !== 8'd6) begin failures++; $display("[TB] FAIL depth_note6 got=%0d want=6", note); end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (held_count !== 4'd3) begin failures++; $display("[TB] FAIL depth_dropped got=%0d want=3", held_count); end
    send_byte(8'hF0); send_byte(8'h2B); idle();
    checks++; if (held_count !== 4'd2) begin failures++; $display("[TB] FAIL depth_held2 got=%0d want=2", held_count); end
    checks++; if (note !== 8'd5)       begin failures++; $display("[TB] FAIL depth_note5 got=%0d want=5", note); end
    do_panic();
  endtask

  task automatic test_repeat();
    send_byte(8'h1C);
    repeat (5) send_byte(8'h1C);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL repeat_held got=%0d want=1", held_count); end
    send_byte(8'hE0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h15);
    send_byte(8'hF0); send_byte(8'h15);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL ignored_held got=%0d want=1", held_count); end
    idle();
    checks++; if (note !== 8'd1) begin failures++; $display("[TB] FAIL ignored_note got=%0d want=1", note); end
    send_byte(8'h24);
    checks++; if (held_count !== 4'd2) begin failures++; $display("[TB] FAIL parser_idle got=%0d want=2", held_count); end
    idle();
    checks++; if (note !== 8'd4) begin failures++; $display("[TB] FAIL parser_note4 got=%0d want=4", note); end
    do_panic();
  endtask

  task automatic test_panic();
    send_byte(8'h1C); send_byte(8'h24);
    checks++; if (held_count !== 4'd2) begin failures++; $display("[TB] FAIL panic_pre got=%0d want=2", held_count); end
    applyStimulus(1'b1, 8'h23, 1'b1, 1'b0);
    checks++; if (held_count !== 4'd0) begin failures++; $display("[TB] FAIL panic_held got=%0d want=0", held_count); end
    idle();
    checks++; if (note !== 8'd0)   begin failures++; $display("[TB] FAIL panic_note got=%0d want=0", note); end
    checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL panic_active got=%0d want=0", active); end
    send_byte(8'hF0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    send_byte(8'h1C);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL rst_abandon got=%0d want=1", held_count); end
    idle();
    checks++; if (note !== 8'd1) begin failures++; $display("[TB] FAIL rst_note got=%0d want=1", note); end
    send_byte(8'hF0); do_panic(); send_byte(8'h24);
    checks++; if (held_count !== 4'd1) begin failures++; $display("[TB] FAIL panic_abandon got=%0d want=1", held_count); end
    do_panic();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send_byte(codes[i]);
    checks++; if (held_count !== 4'(DEPTH)) begin failures++; $display("[TB] FAIL b2b_held got=%0d want=%0d", held_count, DEPTH); end
    idle();
    checks++; if (note !== 8'd8) begin failures++; $display("[TB] FAIL b2b_note got=%0d want=8", note); end
    do_panic();
  endtask

  task automatic test_random();
    logic v, p, r;
    logic [7:0] d;
    int sel;
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 9);
      if (sel <= 5 || sel == 9) d = codes[$urandom_range(0, 12)];
      else if (sel == 6)        d = 8'hF0;
      else if (sel == 7)        d = 8'hE0;
      else                      d = 8'($urandom);
      applyStimulus(v, d, p, r);
      checks++;
      if (held_count !== 4'(mstack.size())) begin
        failures++; $display("[TB] FAIL rand_held cycle=%0d got=%0d want=%0d", n, held_count, mstack.size());
      end
`ifndef NOTE_GAP_EN
      checks++;
      if (note !== 8'(exp_note)) begin
        failures++; $display("[TB] FAIL rand_note cycle=%0d got=%0d want=%0d", n, note, exp_note);
      end
      checks++;
      if (active !== (exp_note != 0)) begin
        failures++; $display("[TB] FAIL rand_active cycle=%0d got=%0d want=%0d", n, active, exp_note != 0);
      end
`endif
    end
    do_panic();
  endtask

`ifdef NOTE_GAP_EN
  task automatic test_gap();
    do_panic();
    send_byte(8'h1C); idle(); idle();
    checks++; if (note !== 8'd1) begin failures++; $display("[TB] FAIL gap_pre got=%0d want=1", note); end
    send_byte(8'h24);
    checks++; if (note !== 8'd1) begin failures++; $display("[TB] FAIL gap_edge got=%0d want=1", note); end
    for (int i = 0; i < GAP; i++) begin
      idle();
      checks++; if (note !== 8'd0) begin failures++; $display("[TB] FAIL gap_silent%0d got=%0d want=0", i, note); end
    end
    idle();
    checks++; if (note !== 8'd4) begin failures++; $display("[TB] FAIL gap_end got=%0d want=4", note); end
    do_panic();
    send_byte(8'h1C); idle(); idle();
    send_byte(8'h24);
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if (note !== 8'd0) begin failures++; $display("[TB] FAIL gap_first%0d got=%0d want=0", i, note); end
    end
    send_byte(8'h23);
    checks++; if (note !== 8'd0) begin failures++; $display("[TB] FAIL gap_restart got=%0d want=0", note); end
    for (int i = 0; i < GAP; i++) begin
      idle();
      checks++; if (note !== 8'd0) begin failures++; $display("[TB] FAIL gap_second%0d got=%0d want=0", i, note); end
    end
    idle();
    checks++; if (note !== 8'd5) begin failures++; $display("[TB] FAIL gap_newest got=%0d want=5", note); end
    do_panic();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifdef NOTE_GAP_EN
    test_gap();
`else
    test_overlay();
    test_depth();
    test_repeat();
    test_panic();
    test_back_to_back();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
